// File: rtl/bus_bridge_master_ctrl.sv
// bus_bridge_master_ctrl: queues UART command frames and replays them on the local bus, returning read data over UART TX
module bus_bridge_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             u_rx_ready,
    input  logic [DATA_WIDTH+ADDR_WIDTH:0]   u_rx_data,
    input  logic                             u_tx_busy,
    output logic [DATA_WIDTH-1:0]            u_tx_data,
    output logic                             u_tx_en,
    output logic                             dvalid,
    output logic                             dmode,
    output logic [ADDR_WIDTH-1:0]            daddr,
    output logic [DATA_WIDTH-1:0]            dwdata,
    input  logic                             dready,
    input  logic [DATA_WIDTH-1:0]            drdata,
    input  logic                             drvalid,
    output logic                             fifo_full,
    output logic [7:0]                       drop_cnt,
    output logic                             rd_timeout
);
    localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];
    localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_RD, TX_WAIT, TX_GAP, TX_DONE} state_t;

    state_t          state, state_nx;
    logic            rx_q;
    logic [FW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count, count_nx;
    logic [TW-1:0]   timer;
    logic            push, pop, accept, timeout_hit;

    assign push        = u_rx_ready && !rx_q;
    assign pop         = (state == REQ) && dvalid && dready;
    assign accept      = push && ((count < FULL_CNT) || pop);
    assign count_nx    = count + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
    assign timeout_hit = timer == TO_LAST;

    // Command storage; a full FIFO may be overwritten at the slot being popped because the head was already latched onto the bus
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= u_rx_data;
    end

    // Edge detection, FIFO pointers/occupancy and drop accounting
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_q      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            rx_q      <= u_rx_ready;
            wr_ptr    <= accept ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count     <= count_nx;
            fifo_full <= count_nx == FULL_CNT;
            drop_cnt  <= (push && !accept && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next-state: one command in flight at a time
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (count != '0) ? REQ : IDLE;
            REQ:     state_nx = pop ? (dmode ? IDLE : WAIT_RD) : REQ;
            WAIT_RD: state_nx = (drvalid || timeout_hit) ? TX_WAIT : WAIT_RD;
            TX_WAIT: state_nx = u_tx_busy ? TX_WAIT : TX_GAP;
            TX_GAP:  state_nx = TX_DONE;
            TX_DONE: state_nx = u_tx_busy ? TX_DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered bus request, read timer, read-data capture and strobes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dvalid     <= 1'b0;
            dmode      <= 1'b0;
            daddr      <= '0;
            dwdata     <= '0;
            u_tx_data  <= '0;
            u_tx_en    <= 1'b0;
            rd_timeout <= 1'b0;
            timer      <= '0;
        end else begin
            u_tx_en    <= (state == TX_WAIT) && !u_tx_busy;
            rd_timeout <= (state == WAIT_RD) && !drvalid && timeout_hit;
            timer      <= (state == WAIT_RD) ? timer + 1'b1 : '0;
            if (state == IDLE && count != '0) begin
                dvalid                  <= 1'b1;
                {dmode, dwdata, daddr}  <= mem[rd_ptr];
            end else if (pop) begin
                dvalid <= 1'b0;
            end
            if (state == WAIT_RD && drvalid)
                u_tx_data <= drdata;
            else if (state == WAIT_RD && timeout_hit)
                u_tx_data <= '1;
        end
    end
endmodule
